lenet_lite_classifier: RTL and testbench

// Serial single-layer digit classifier. On a go pulse it reads one 32x32 frame (1024 pixels) from an external pixel ROM.
// It multiply-accumulates each pixel against 10 per-class weights from an external weight ROM, then picks the argmax class.
// It reports the result as a 4-bit digit with a one-cycle ready pulse. It sits between the frame-feed/ROM front end and the result logger.

---
 rtl/lenet_lite_classifier.sv | 113 +++++++++++
 tb/tb_lenet_lite_classifier.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lenet_lite_classifier.sv
// Serial single-layer digit classifier: streams a 32x32 frame against 10 per-class weight planes,
// then takes the argmax of the 10 signed scores and reports it with a one-cycle ready pulse.
module lenet_lite_classifier #(
   parameter int unsigned WD   = 31,
   parameter int unsigned WW   = 8,
   parameter int unsigned ACCW = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 go,
   output logic                 cena_src,
   output logic [9:0]           aa_src,
   input  logic [WD:0]          qa_src,
   output logic                 cena_w,
   output logic [13:0]          aa_w,
   input  logic signed [WW-1:0] qa_w,
   output logic [3:0]           digit,
   output logic                 ready
);

   localparam int unsigned PW = WW + 10;
   localparam logic [13:0] LastIssue = 14'd10239;

   typedef enum logic [1:0] {StIdle, StRun, StArgmax, StDone} state_e;

   state_e                 state;
   logic signed [ACCW-1:0] acc [10];
   logic                   pipe_v;
   logic [3:0]             pipe_c;
   logic [3:0]             am_idx;
   logic [3:0]             best_idx;
   logic signed [ACCW-1:0] best;

   logic signed [PW-1:0]   pix_ext;
   logic signed [PW-1:0]   w_ext;
   logic signed [PW-1:0]   prod;
   logic signed [ACCW-1:0] prod_ext;
   logic                   unused_src;

   // Pixel is unsigned 9-bit; only the weight carries a sign.
   assign pix_ext    = {{(PW - 9){1'b0}}, qa_src[8:0]};
   assign w_ext      = {{(PW - WW){qa_w[WW-1]}}, qa_w};
   assign prod       = pix_ext * w_ext;
   assign prod_ext   = {{(ACCW - PW){prod[PW-1]}}, prod};
   assign unused_src = ^qa_src[WD:9];

   always_ff @(posedge clk) begin
      if (rstn) begin
         state    <= StIdle;
         digit    <= 4'd0;
         ready    <= 1'b0;
         cena_src <= 1'b1;
         cena_w   <= 1'b1;
         aa_src   <= 10'd0;
         aa_w     <= 14'd0;
         pipe_v   <= 1'b0;
         pipe_c   <= 4'd0;
         am_idx   <= 4'd0;
         best_idx <= 4'd0;
         best     <= '0;
         for (int i = 0; i < 10; i++) acc[i] <= '0;
      end else begin
         ready  <= 1'b0;
         // ROM data for the address issued this cycle arrives next cycle; tag it with its class.
         pipe_v <= ~cena_w;
         pipe_c <= aa_w[13:10];
         unique case (state)
            StIdle: begin
               if (go) begin
                  state    <= StRun;
                  cena_src <= 1'b0;
                  cena_w   <= 1'b0;
                  aa_src   <= 10'd0;
                  aa_w     <= 14'd0;
                  for (int i = 0; i < 10; i++) acc[i] <= '0;
               end
            end
            StRun: begin
               if (!cena_w) begin
                  if (aa_w == LastIssue) begin
                     cena_src <= 1'b1;
                     cena_w   <= 1'b1;
                  end else begin
                     aa_w   <= aa_w + 14'd1;
                     aa_src <= aa_src + 10'd1;
                  end
               end
               if (pipe_v) acc[pipe_c] <= acc[pipe_c] + prod_ext;
               // Final product in flight and no further issue: this is the last accumulate.
               if (pipe_v && cena_w) begin
                  state  <= StArgmax;
                  am_idx <= 4'd0;
               end
            end
            StArgmax: begin
               if (am_idx == 4'd0 || acc[am_idx] > best) begin
                  best     <= acc[am_idx];
                  best_idx <= am_idx;
               end
               if (am_idx == 4'd9) state <= StDone;
               else am_idx <= am_idx + 4'd1;
            end
            StDone: begin
               digit <= best_idx;
               ready <= 1'b1;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lenet_lite_classifier.sv
// Directed + randomized bench for lenet_lite_classifier with behavioural ROMs and an
// argmax reference model computed straight from the frame and weight arrays.
module tb_lenet_lite_classifier;

   logic              clk = 1'b0;
   logic              rstn = 1'b1;
   logic              go = 1'b0;
   logic              cena_src, cena_w, ready;
   logic [9:0]        aa_src;
   logic [13:0]       aa_w;
   logic [31:0]       qa_src = '0;
   logic signed [7:0] qa_w = '0;
   logic [3:0]        digit;

   logic [31:0]       pix  [1024];
   logic signed [7:0] wmem [10240];

   int cyc = 0;
   int src_low = 0, w_low = 0, ready_cnt = 0;
   int tests = 0, fails = 0;
   int t0;

   lenet_lite_classifier dut (
      .clk(clk), .rstn(rstn), .go(go),
      .cena_src(cena_src), .aa_src(aa_src), .qa_src(qa_src),
      .cena_w(cena_w), .aa_w(aa_w), .qa_w(qa_w),
      .digit(digit), .ready(ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!cena_src) qa_src <= pix[aa_src];
      if (!cena_w) qa_w <= wmem[aa_w];
   end

   always @(negedge clk) begin
      if (!cena_src) src_low <= src_low + 1;
      if (!cena_w) w_low <= w_low + 1;
      if (ready) ready_cnt <= ready_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_digit();
      int best = 0, bi = 0, s;
      for (int c = 0; c < 10; c++) begin
         s = 0;
         for (int p = 0; p < 1024; p++)
            s += int'({23'd0, pix[p][8:0]}) * int'(wmem[c * 1024 + p]);
         if (c == 0 || s > best) begin
            best = s;
            bi   = c;
         end
      end
      return bi;
   endfunction

   task automatic fill_pix(input int v);
      for (int p = 0; p < 1024; p++) pix[p] = v;
   endtask

   task automatic fill_w(input int c_sel, input int v_sel, input int v_other);
      for (int i = 0; i < 10240; i++) wmem[i] = 8'((i / 1024 == c_sel) ? v_sel : v_other);
   endtask

   task automatic start();
      @(negedge clk);
      go = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      go = 1'b0;
   endtask

   // Waits for ready with a bound, then checks latency, digit, pulse width and read counts.
   task automatic finish_frame(input string tag, input int s0, input int w0, input int exp_d);
      while (!ready && (cyc - t0) < 11000) @(negedge clk);
      check({tag, "_ready_seen"}, 32'(ready), 32'd1);
      check({tag, "_latency"}, 32'(cyc - t0), 32'd10252);
      check({tag, "_digit"}, 32'(digit), 32'(exp_d));
      @(negedge clk);
      check({tag, "_ready_one_cycle"}, 32'(ready), 32'd0);
      check({tag, "_src_reads"}, 32'(src_low - s0), 32'd10240);
      check({tag, "_w_reads"}, 32'(w_low - w0), 32'd10240);
   endtask

   task automatic run_frame(input string tag);
      int s0, w0, d;
      d = ref_digit();
      start();
      s0 = src_low;
      w0 = w_low;
      finish_frame(tag, s0, w0, d);
   endtask

   initial begin
      int s0, w0, rc, d;
      fill_pix(0);
      fill_w(0, 0, 0);

      // Reset, with go asserted alongside reset (must be ignored).
      go = 1'b1;
      repeat (5) @(negedge clk);
      go = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      check("rst_digit", 32'(digit), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_cena_src", 32'(cena_src), 32'd1);
      check("rst_cena_w", 32'(cena_w), 32'd1);
      check("rst_no_reads", 32'(src_low + w_low), 32'd0);

      // All-ones image, only class 7 weighted.
      fill_pix(1);
      fill_w(7, 1, 0);
      check("model_c2", 32'(ref_digit()), 32'd7);
      run_frame("c2");

      // Zero weights with a random image: every score ties at 0.
      for (int p = 0; p < 1024; p++) pix[p] = $urandom;
      fill_w(0, 0, 0);
      run_frame("c3");

      // Negative scores: -261120 beats -522240.
      fill_pix(255);
      fill_w(2, -1, -2);
      check("model_c4", 32'(ref_digit()), 32'd2);
      run_frame("c4");

      // Random frame with a stray go mid-run.
      for (int p = 0; p < 1024; p++) pix[p] = $urandom;
      for (int i = 0; i < 10240; i++) wmem[i] = 8'($urandom);
      d = ref_digit();
      rc = ready_cnt;
      start();
      s0 = src_low;
      w0 = w_low;
      repeat (5000) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      finish_frame("c5a", s0, w0, d);
      repeat (50) @(negedge clk);
      check("c5_single_ready", 32'(ready_cnt - rc), 32'd1);
      check("c5_idle_after", 32'(cena_src), 32'd1);

      // New image favouring class 4.
      for (int i = 0; i < 10240; i++) wmem[i] = 8'(((i % 1024) % 10 == i / 1024) ? 1 : 0);
      for (int p = 0; p < 1024; p++) pix[p] = (p % 10 == 4) ? 32'd1 : 32'd0;
      check("model_c5b", 32'(ref_digit()), 32'd4);
      run_frame("c5b");

      // Reset in mid-run, then a fresh frame.
      fill_pix(1);
      fill_w(7, 1, 0);
      start();
      repeat (5000) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      rstn = 1'b0;
      rc = ready_cnt;
      check("c6_digit", 32'(digit), 32'd0);
      check("c6_ready", 32'(ready), 32'd0);
      check("c6_cena_src", 32'(cena_src), 32'd1);
      check("c6_cena_w", 32'(cena_w), 32'd1);
      check("c6_aa_src", 32'(aa_src), 32'd0);
      check("c6_aa_w", 32'(aa_w), 32'd0);
      s0 = src_low;
      repeat (5400) @(negedge clk);
      check("c6_no_ready", 32'(ready_cnt - rc), 32'd0);
      check("c6_no_reads", 32'(src_low - s0), 32'd0);
      run_frame("c6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
